qspi_ctrl: RTL

QSPI_CTRL -- requirements
Module: qspi_ctrl

---
 rtl/qspi_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/qspi_ctrl.sv
// Quad-SPI master for one flash and two RAM devices: command on a single line,
// then address and data four bits per SPI clock.
module qspi_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [24:0] addr,
  input  logic        write,
  input  logic [1:0]  len,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  input  logic [3:0]  qspi_data_in,
  output logic [3:0]  qspi_data_out,
  output logic [3:0]  qspi_data_oe,
  output logic        qspi_clk_out,
  output logic        qspi_flash_select,
  output logic        qspi_ram_a_select,
  output logic        qspi_ram_b_select
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DONE} state_t;

  state_t      state, state_next;
  logic        phase;
  logic [2:0]  cnt;
  logic [24:0] addr_q;
  logic        write_q;
  logic [1:0]  len_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        reject;
  logic        active;
  logic [7:0]  cmd_byte;
  logic [23:0] addr_field;
  logic [4:0]  nib_pos;

  assign reject     = start && write && !addr[24];
  assign active     = (state == CMD) || (state == ADDR) || (state == DUMMY) || (state == DATA);
  assign cmd_byte   = write_q ? 8'h38 : 8'hEB;
  assign addr_field = addr_q[24] ? {2'b00, addr_q[21:0]} : addr_q[23:0];
  // Nibble cnt maps to byte cnt/2, high nibble on even cnt.
  assign nib_pos    = {cnt[2:1], ~cnt[0], 2'b00};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next        = state;
    busy              = (state != IDLE);
    done              = (state == DONE);
    err               = err_q;
    rdata             = rdata_q;
    qspi_data_out     = '0;
    qspi_data_oe      = '0;
    qspi_clk_out      = active && phase;
    qspi_flash_select = 1'b1;
    qspi_ram_a_select = 1'b1;
    qspi_ram_b_select = 1'b1;

    if (active) begin
      if (!addr_q[24])     qspi_flash_select = 1'b0;
      else if (addr_q[23]) qspi_ram_b_select = 1'b0;
      else                 qspi_ram_a_select = 1'b0;
    end

    unique case (state)
      IDLE: if (start && !reject) state_next = CMD;
      CMD: begin
        qspi_data_out = {3'b000, cmd_byte[3'd7 - cnt]};
        qspi_data_oe  = 4'b0001;
        if (phase && cnt == 3'd7) state_next = ADDR;
      end
      ADDR: begin
        qspi_data_out = addr_field[{3'd5 - cnt, 2'b00} +: 4];
        qspi_data_oe  = 4'b1111;
        if (phase && cnt == 3'd5) state_next = write_q ? DATA : DUMMY;
      end
      DUMMY: if (phase && cnt == 3'd5) state_next = DATA;
      DATA: begin
        if (write_q) begin
          qspi_data_out = wdata_q[nib_pos +: 4];
          qspi_data_oe  = 4'b1111;
        end
        if (phase && cnt == {len_q, 1'b1}) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase   <= 1'b0;
      cnt     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      len_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && reject;

      if (state_next != state || !active) begin
        phase <= 1'b0;
        cnt   <= '0;
      end else begin
        phase <= ~phase;
        if (phase) cnt <= cnt + 3'd1;
      end

      if (state == IDLE && start && !reject) begin
        addr_q  <= addr;
        write_q <= write;
        len_q   <= len;
        wdata_q <= wdata;
        if (!write) rdata_q <= '0;
      end

      // Read data is sampled on the edge that raises the SPI clock.
      if (state == DATA && !write_q && !phase)
        rdata_q[nib_pos +: 4] <= qspi_data_in;
    end
  end

endmodule
